epl_column_decode_burst: RTL and testbench
==========================================

# epl_column_decode_burst

Registered, parametrised column decoder with a burst sequencer for the EPLFFRAM02 array datapath. Converts a 2^AC_W-way column address into a one-hot column select and optionally walks consecutive columns with wrap-around, one column per advance strobe from the array timing controller. Replaces the fixed 1-bit combinational column decode for wider column muxing and multi-column (row-page) accesses.

## Interface
- AC_W, 1: column address width; column count COLS = 2**AC_W (AC_W >= 1).
- LEN_W, AC_W+1: burst length width (derived, do not override).

- pClk_i  input  1  clock, all state on rising edge.
- pRstn_i  input  1  asynchronous, active-low reset.
- pStart_i  input  1  start request; sampled only in IDLE.
- pAc_i  input  AC_W  start column, sampled with pStart_i.
- pLen_i  input  LEN_W  burst length in columns; 0 means COLS.
- pAdv_i  input  1  advance strobe; consumes the current column.
- pAcy_o  output  COLS  registered one-hot column select; all-zero when no column is active.
- pAcCur_o  output  AC_W  registered current column index.
- pBusy_o  output  1  high in RUN and DONE.
- pLast_o  output  1  high in RUN when exactly one column remains.
- pDone_o  output  1  single-cycle pulse after the final advance.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: pAcy_o = 0, pBusy_o = 0. On pStart_i = 1: load cur = pAc_i, rem = (pLen_i == 0 ? COLS : min(pLen_i, COLS)), go to RUN. pAdv_i ignored in IDLE.
- RUN: pAcy_o = 1 << cur. On pAdv_i = 1 and rem > 1: cur = cur + 1 mod COLS (wraps COLS-1 -> 0), rem = rem - 1. On pAdv_i = 1 and rem == 1: go to DONE.
- DONE: one cycle; pAcy_o = 0, pDone_o = 1, cur holds its last value, then IDLE.
- pStart_i in RUN or DONE: ignored, not queued.
- pLen_i > COLS: saturates to COLS.
- pAcy_o is always either all-zero or exactly one-hot. No other value is legal.

## Timing
- Reset (async assert, sync-released by the system): state IDLE, pAcy_o = 0, pAcCur_o = 0, pBusy_o = 0, pLast_o = 0, pDone_o = 0, rem = 0.
- Start latency: pStart_i at edge N -> pAcy_o one-hot and pBusy_o = 1 from edge N+1.
- Advance latency: pAdv_i at edge N -> next column at edge N+1. Back-to-back pAdv_i gives one column per cycle.
- Final pAdv_i at edge N -> pAcy_o = 0, pDone_o = 1 at N+1. IDLE at N+2, with pStart_i accepted at edge N+2.
- pLast_o is registered together with pAcy_o and is valid in the same cycle as the final column.
- Reset asserted mid-burst: outputs clear immediately with no pDone_o, and the burst is abandoned.

## Configuration
- EPL_COLDEC_DIR_EN defined:
  - Adds the port pDir_i (input, 1 bit), sampled with pStart_i.
  - pDir_i = 0 gives an incrementing burst.
  - pDir_i = 1 gives a decrementing burst: cur = cur - 1 mod COLS, wrapping 0 -> COLS-1.
  - The direction is held for the whole burst.
- EPL_COLDEC_DIR_EN undefined: the pDir_i port is absent and every burst increments.

## Test plan
- Reset: hold pRstn_i = 0 mid-RUN (AC_W=2) -> pAcy_o = 4'b0000, pBusy_o = 0 immediately, and no pDone_o after release.
- Single column: AC_W=1, pStart_i with pAc_i=1, pLen_i=1, then one pAdv_i -> pAcy_o = 2'b10 with pLast_o = 1, then 2'b00 with pDone_o = 1 for one cycle.
- Wrap: AC_W=2, pAc_i=3, pLen_i=3, pAdv_i held high -> pAcy_o sequence 1000, 0001, 0010, then 0000 with pDone_o.
- Full row: AC_W=3, pLen_i=0, pAc_i=5 -> 8 columns 5,6,7,0,1,2,3,4, then pDone_o. pLen_i=15 gives the same 8 columns.
- Ignored inputs: pStart_i during RUN -> cur and rem unchanged. pAdv_i in IDLE -> no state change. Gapped pAdv_i -> pAcy_o holds between strobes.
- With EPL_COLDEC_DIR_EN: AC_W=2, pDir_i=1, pAc_i=1, pLen_i=3 -> columns 1, 0, 3, then pDone_o.

Source files
------------

// File: rtl/epl_column_decode_burst.sv
// epl_column_decode_burst
// Registered one-hot column decoder with a wrap-around burst sequencer for the
// EPLFFRAM02 array datapath. One column is consumed per advance strobe.
// Optional build macro: EPL_COLDEC_DIR_EN adds pDir_i for decrementing bursts.
module epl_column_decode_burst #(
    parameter int AC_W  = 1,
    parameter int LEN_W = AC_W + 1
) (
    input  logic                   pClk_i,
    input  logic                   pRstn_i,
    input  logic                   pStart_i,
    input  logic [AC_W-1:0]        pAc_i,
    input  logic [LEN_W-1:0]       pLen_i,
    input  logic                   pAdv_i,
`ifdef EPL_COLDEC_DIR_EN
    input  logic                   pDir_i,
`endif
    output logic [(2**AC_W)-1:0]   pAcy_o,
    output logic [AC_W-1:0]        pAcCur_o,
    output logic                   pBusy_o,
    output logic                   pLast_o,
    output logic                   pDone_o
);

    localparam int               COLS   = 2 ** AC_W;
    localparam logic [LEN_W-1:0] COLS_L = LEN_W'(COLS);
    localparam logic [LEN_W-1:0] ONE_L  = LEN_W'(1);
    localparam logic [LEN_W-1:0] TWO_L  = LEN_W'(2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    logic [AC_W-1:0]   cur;
    logic [AC_W-1:0]   next_cur;
    logic [LEN_W-1:0]  rem;
    logic [LEN_W-1:0]  len_sat;
    logic [COLS-1:0]   acy;
    logic              busy;
    logic              last;
    logic              done;
`ifdef EPL_COLDEC_DIR_EN
    logic              dir_q;
`endif

    // One-hot select for a column index; the index width covers every column exactly.
    function automatic logic [COLS-1:0] onehot(input logic [AC_W-1:0] idx);
        logic [COLS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Burst length: zero and anything wider than the row both mean a full row.
    always_comb begin
        // NOTE: default assigned first so every path drives len_sat and no latch is inferred.
        len_sat = pLen_i;
        if (pLen_i == '0 || pLen_i > COLS_L) begin
            len_sat = COLS_L;
        end
    end

    // Next column in burst order; AC_W-bit arithmetic gives the wrap for free.
`ifdef EPL_COLDEC_DIR_EN
    assign next_cur = dir_q ? (cur - AC_W'(1)) : (cur + AC_W'(1));
`else
    assign next_cur = cur + AC_W'(1);
`endif

    // Burst FSM with all outputs registered alongside the state.
    always_ff @(posedge pClk_i or negedge pRstn_i) begin
        if (!pRstn_i) begin
            // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
            state <= S_IDLE;
            cur   <= '0;
            rem   <= '0;
            acy   <= '0;
            busy  <= 1'b0;
            last  <= 1'b0;
            done  <= 1'b0;
`ifdef EPL_COLDEC_DIR_EN
            dir_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (pStart_i) begin
                        state <= S_RUN;
                        cur   <= pAc_i;
                        rem   <= len_sat;
                        acy   <= onehot(pAc_i);
                        busy  <= 1'b1;
                        last  <= (len_sat == ONE_L);
`ifdef EPL_COLDEC_DIR_EN
                        dir_q <= pDir_i;
`endif
                    end
                end
                S_RUN: begin
                    if (pAdv_i) begin
                        if (rem > ONE_L) begin
                            cur  <= next_cur;
                            rem  <= rem - ONE_L;
                            acy  <= onehot(next_cur);
                            last <= (rem == TWO_L);
                        end else begin
                            // Final column consumed: cur keeps its last value through DONE.
                            state <= S_DONE;
                            rem   <= '0;
                            acy   <= '0;
                            last  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    acy   <= '0;
                    busy  <= 1'b0;
                    last  <= 1'b0;
                end
            endcase
        end
    end

    assign pAcy_o   = acy;
    assign pAcCur_o = cur;
    assign pBusy_o  = busy;
    assign pLast_o  = last;
    assign pDone_o  = done;

endmodule

// File: tb/tb_epl_column_decode_burst.sv
// Testbench for epl_column_decode_burst: an AC_W=3 instance checked every cycle
// against a column-queue model plus directed literals, and an AC_W=1 instance
// checked with directed literals only.
module tb_epl_column_decode_burst;

    localparam int AW = 3;
    localparam int LW = AW + 1;
    localparam int NC = 2 ** AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // AC_W=3 instance signals
    logic          start, adv, dir;
    logic [AW-1:0] ac;
    logic [LW-1:0] len;
    logic [NC-1:0] acy;
    logic [AW-1:0] cur;
    logic          busy, last, done;

    // AC_W=1 instance signals
    logic          s1_start, s1_adv;
    logic [0:0]    s1_ac;
    logic [1:0]    s1_len;
    logic [1:0]    s1_acy;
    logic [0:0]    s1_cur;
    logic          s1_busy, s1_last, s1_done;
`ifdef EPL_COLDEC_DIR_EN
    logic          s1_dir;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;
    int cols [8];

    epl_column_decode_burst #(.AC_W(AW)) u_dut3 (
        .pClk_i  (clk),
        .pRstn_i (rst_n),
        .pStart_i(start),
        .pAc_i   (ac),
        .pLen_i  (len),
        .pAdv_i  (adv),
`ifdef EPL_COLDEC_DIR_EN
        .pDir_i  (dir),
`endif
        .pAcy_o  (acy),
        .pAcCur_o(cur),
        .pBusy_o (busy),
        .pLast_o (last),
        .pDone_o (done)
    );

    epl_column_decode_burst #(.AC_W(1)) u_dut1 (
        .pClk_i  (clk),
        .pRstn_i (rst_n),
        .pStart_i(s1_start),
        .pAc_i   (s1_ac),
        .pLen_i  (s1_len),
        .pAdv_i  (s1_adv),
`ifdef EPL_COLDEC_DIR_EN
        .pDir_i  (s1_dir),
`endif
        .pAcy_o  (s1_acy),
        .pAcCur_o(s1_cur),
        .pBusy_o (s1_busy),
        .pLast_o (s1_last),
        .pDone_o (s1_done)
    );

    // Model: a burst is the list of columns still to visit; advancing pops one.
    int q[$];
    bit m_done;
    int m_cur;
    int m_n, m_step;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_done = 1'b0;
            m_cur  = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (q.size() > 0) begin
            if (adv) begin
                m_cur = q.pop_front();
                if (q.size() == 0) m_done = 1'b1;
            end
        end else if (start) begin
            m_n = (len == 0 || int'(len) > NC) ? NC : int'(len);
`ifdef EPL_COLDEC_DIR_EN
            m_step = dir ? -1 : 1;
`else
            m_step = 1;
`endif
            for (int i = 0; i < m_n; i++) begin
                q.push_back(((int'(ac) + m_step * i) % NC + NC) % NC);
            end
        end
    end

    // Per-cycle comparison of the AC_W=3 instance against the model.
    logic [NC-1:0]      e_acy;
    logic [NC+AW+2:0]   exp_v, act_v;
    always @(negedge clk) begin
        if (cmp_en) begin
            e_acy = '0;
            if (q.size() > 0) begin
                e_acy[q[0]] = 1'b1;
                exp_v = {e_acy, AW'(q[0]), 1'b1, (q.size() == 1), 1'b0};
            end else if (m_done) begin
                exp_v = {e_acy, AW'(m_cur), 1'b1, 1'b0, 1'b1};
            end else begin
                exp_v = {e_acy, AW'(m_cur), 1'b0, 1'b0, 1'b0};
            end
            act_v = {acy, cur, busy, last, done};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL model_cmp t=%0t actual={acy,cur,busy,last,done}=%b required=%b",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Present a start request for one cycle on the AC_W=3 instance.
    task automatic do_start(input int a, input int l, input bit d);
        start = 1'b1;
        ac    = AW'(a);
        len   = LW'(l);
        dir   = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Hold advance high and check each expected column, then the DONE cycle.
    task automatic walk(input int exp_cols [8], input int n, input string tag);
        adv = 1'b1;
        for (int i = 0; i < n; i++) begin
            check({tag, "_acy"}, 32'(acy), 32'(1) << exp_cols[i]);
            check({tag, "_last"}, 32'(last), (i == n - 1) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        adv = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_acy"}, 32'(acy), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd1);
        check({tag, "_done_cur"}, 32'(cur), 32'(exp_cols[n-1]));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; adv = 1'b0; dir = 1'b0; ac = '0; len = '0;
        s1_start = 1'b0; s1_adv = 1'b0; s1_ac = '0; s1_len = '0;
`ifdef EPL_COLDEC_DIR_EN
        s1_dir = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_acy", 32'(acy), 32'd0);
        check("rst_cur", 32'(cur), 32'd0);
        check("rst_busy_last_done", 32'({busy, last, done}), 32'd0);
        check("rst1_acy", 32'(s1_acy), 32'd0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);

        // Advance while idle does nothing.
        adv = 1'b1;
        repeat (2) @(negedge clk);
        adv = 1'b0;
        check("idle_adv_busy", 32'(busy), 32'd0);
        check("idle_adv_acy", 32'(acy), 32'd0);

        // Full row from column 5, length 0 then saturated length 15.
        cols = '{5, 6, 7, 0, 1, 2, 3, 4};
        do_start(5, 0, 1'b0);
        walk(cols, 8, "row0");
        @(negedge clk);
        check("row0_idle_busy", 32'(busy), 32'd0);
        check("row0_idle_cur", 32'(cur), 32'd4);
        do_start(5, 15, 1'b0);
        walk(cols, 8, "row15");
        @(negedge clk);

        // Wrap 6,7,0, then a start held through DONE is only taken in IDLE.
        cols = '{6, 7, 0, 0, 0, 0, 0, 0};
        do_start(6, 3, 1'b0);
        walk(cols, 3, "wrap");
        start = 1'b1; ac = AW'(0); len = LW'(2);
        @(negedge clk);
        check("start_in_done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        cols = '{0, 1, 0, 0, 0, 0, 0, 0};
        walk(cols, 2, "b2b");
        @(negedge clk);

        // Start during RUN is ignored; gapped advances hold the column.
        do_start(2, 4, 1'b0);
        start = 1'b1; ac = AW'(7); len = LW'(1);
        @(negedge clk);
        start = 1'b0;
        check("run_start_acy", 32'(acy), 32'h04);
        check("run_start_last", 32'(last), 32'd0);
        adv = 1'b1;
        @(negedge clk);
        adv = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("gap_hold_acy", 32'(acy), 32'h08);
            @(negedge clk);
        end
        cols = '{3, 4, 5, 0, 0, 0, 0, 0};
        walk(cols, 3, "gap");
        @(negedge clk);

        // Reset mid-burst clears outputs at once and never yields a done pulse.
        do_start(1, 4, 1'b0);
        adv = 1'b1;
        @(negedge clk);
        adv = 1'b0;
        check("pre_rst_acy", 32'(acy), 32'h04);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_acy", 32'(acy), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_done", 32'({busy, done}), 32'd0);
        end

`ifdef EPL_COLDEC_DIR_EN
        // Decrementing burst 1,0,7.
        cols = '{1, 0, 7, 0, 0, 0, 0, 0};
        do_start(1, 3, 1'b1);
        walk(cols, 3, "dec");
        @(negedge clk);
        dir = 1'b0;
`endif

        // AC_W=1: single column at index 1.
        s1_start = 1'b1; s1_ac = 1'b1; s1_len = 2'd1;
        @(negedge clk);
        s1_start = 1'b0;
        check("s1_acy", 32'(s1_acy), 32'h2);
        check("s1_last", 32'(s1_last), 32'd1);
        check("s1_busy", 32'(s1_busy), 32'd1);
        s1_adv = 1'b1;
        @(negedge clk);
        s1_adv = 1'b0;
        check("s1_done_acy", 32'(s1_acy), 32'd0);
        check("s1_done", 32'(s1_done), 32'd1);
        @(negedge clk);
        check("s1_idle", 32'({s1_busy, s1_done}), 32'd0);
        check("s1_idle_cur", 32'(s1_cur), 32'd1);

        // AC_W=1: length 3 saturates to 2 columns, 1 then 0.
        s1_start = 1'b1; s1_ac = 1'b1; s1_len = 2'd3;
        @(negedge clk);
        s1_start = 1'b0;
        check("s1_sat_acy0", 32'(s1_acy), 32'h2);
        check("s1_sat_last0", 32'(s1_last), 32'd0);
        s1_adv = 1'b1;
        @(negedge clk);
        check("s1_sat_acy1", 32'(s1_acy), 32'h1);
        check("s1_sat_last1", 32'(s1_last), 32'd1);
        @(negedge clk);
        s1_adv = 1'b0;
        check("s1_sat_done", 32'(s1_done), 32'd1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
